uart_alu: RTL and testbench

//  Parametrised UART-attached arithmetic unit; successor of the fixed 32-bit UART adder.

---
 rtl/uart_alu_pkg.sv | 59 +++++
 rtl/uart_alu_uart.sv | 113 +++++++++++
 rtl/uart_alu.sv | 187 ++++++++++++++++++
 tb/tb_uart_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types, constants and the ALU function for the UART-attached arithmetic unit.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'h01,
        OP_SUB = 8'h02,
        OP_AND = 8'h03,
        OP_OR  = 8'h04,
        OP_XOR = 8'h05
    } opcode_e;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_TX_RES,
        S_TX_FLAG,
        S_TX_ERR
    } state_e;

    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;

    function automatic logic op_legal(input logic [7:0] op);
        return (op >= 8'(OP_ADD)) && (op <= 8'(OP_XOR));
    endfunction

    // Returns {carry, result} packed into the low w+1 bits; operands are w bits zero-extended.
    function automatic logic [64:0] alu_calc(input logic [7:0] op, input logic [63:0] a,
                                             input logic [63:0] b, input int unsigned w);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] r;
        logic        c;
        mask = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
        full = {1'b0, a} + {1'b0, b};
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                r = full[63:0];
                c = full[w[6:0]];
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        r = r & mask;
        return 65'(r) | (65'(c) << w);
    endfunction

endpackage

// File: rtl/uart_alu_uart.sv
// 8N1 UART core: mid-bit sampling receiver and shift-register transmitter.
module uart_alu_uart #(
    parameter int unsigned CLK_FREQ = 10000000,
    parameter int unsigned UART_BPS = 256000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       send_data,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    localparam int unsigned BIT_CYC = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam int unsigned DW      = $clog2(BIT_CYC + 1);

    logic          rx_s1, rx_s2;
    logic          rx_act;
    logic [DW-1:0] rx_div;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic          tx_act;
    logic [DW-1:0] tx_div;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // Receiver: wait half a bit into the start bit, then sample once per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act  <= 1'b0;
            rx_div  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            rx_done <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (!rx_act) begin
                if (!rx_s2) begin
                    rx_act <= 1'b1;
                    rx_div <= DW'(HALF);
                    rx_bit <= '0;
                end
            end else if (rx_div != '0) begin
                rx_div <= rx_div - DW'(1);
            end else begin
                rx_div <= DW'(BIT_CYC - 1);
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_act <= 1'b0;
                    else       rx_bit <= 4'd1;
                end else if (rx_bit <= 4'd8) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    rx_act  <= 1'b0;
                    rx_data <= rx_sh;
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Transmitter: start, 8 data bits LSB first, stop; tx_done at end of the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_act  <= 1'b0;
            tx_div  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_act) begin
                tx <= 1'b1;
                if (send_data) begin
                    tx_act <= 1'b1;
                    tx_sh  <= {1'b1, tx_data, 1'b0};
                    tx_div <= DW'(BIT_CYC - 1);
                    tx_bit <= '0;
                    tx     <= 1'b0;
                end
            end else if (tx_div != '0) begin
                tx_div <= tx_div - DW'(1);
            end else if (tx_bit == 4'd9) begin
                tx_act  <= 1'b0;
                tx_done <= 1'b1;
                tx      <= 1'b1;
            end else begin
                tx_bit <= tx_bit + 4'd1;
                tx_div <= DW'(BIT_CYC - 1);
                tx     <= tx_sh[1];
                tx_sh  <= {1'b1, tx_sh[9:1]};
            end
        end
    end

endmodule

// File: rtl/uart_alu.sv
// UART-attached ALU: receives opcode + two operands, returns result bytes and a flag byte.
module uart_alu
    import uart_alu_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 10000000,
    parameter int unsigned UART_BPS    = 256000,
    parameter int unsigned OP_BYTES    = 4,
    parameter int unsigned TIMEOUT_CYC = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic RX,
    output logic TX,
    output logic busy,
    output logic op_done,
    output logic frame_err
);

    localparam int unsigned W   = 8 * OP_BYTES;
    localparam int unsigned WP1 = W + 1;
    localparam int unsigned CW  = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam int unsigned GW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OP_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0]     op_q, op_d, tx_data_q, tx_data_d;
    logic           carry_q, carry_d, zero_q, zero_d;
    logic           busy_d, op_done_d, frame_err_d, send_q, send_d;
    logic [W:0]     alu_c;
    logic [7:0]     flag_c;
    logic [7:0]     rx_data;
    logic           rx_done, tx_done;

    uart_alu_uart #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_uart (
        .clk       (clk),
        .rst_n     (~rst),
        .rx        (RX),
        .tx        (TX),
        .tx_data   (tx_data_q),
        .send_data (send_q),
        .tx_done   (tx_done),
        .rx_data   (rx_data),
        .rx_done   (rx_done)
    );

    always_comb begin
        alu_c = WP1'(alu_calc(op_q, 64'(a_q), 64'(b_q), W));
        flag_c = '0;
        flag_c[3'(FLAG_ZERO)]  = zero_q;
        flag_c[3'(FLAG_CARRY)] = carry_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            tx_data_q <= '0;
            send_q    <= 1'b0;
            busy      <= 1'b0;
            op_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            tx_data_q <= tx_data_d;
            send_q    <= send_d;
            busy      <= busy_d;
            op_done   <= op_done_d;
            frame_err <= frame_err_d;
        end
    end

    // Each send pulse is issued on the transition that selects the byte, so it lasts one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy;
        op_done_d   = 1'b0;
        frame_err_d = 1'b0;
        send_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_done) begin
                    op_d   = rx_data;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    gap_d  = '0;
                    if (op_legal(rx_data)) begin
                        state_d = S_RX_A;
                    end else begin
                        state_d   = S_TX_ERR;
                        tx_data_d = ERR_BYTE;
                        send_d    = 1'b1;
                    end
                end
            end
            S_RX_A, S_RX_B: begin
                if (rx_done) begin
                    gap_d = '0;
                    if (state_q == S_RX_A) a_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    else                   b_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_RX_A) ? S_RX_B : S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (gap_q == GAP_LAST) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    gap_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_EXEC: begin
                res_d     = alu_c[W-1:0];
                carry_d   = alu_c[W];
                zero_d    = (alu_c[W-1:0] == '0);
                tx_data_d = alu_c[7:0];
                send_d    = 1'b1;
                cnt_d     = '0;
                state_d   = S_TX_RES;
            end
            S_TX_RES: begin
                if (tx_done) begin
                    send_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        tx_data_d = flag_c;
                        state_d   = S_TX_FLAG;
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        res_d     = res_q >> 8;
                        tx_data_d = res_d[7:0];
                    end
                end
            end
            S_TX_FLAG: begin
                if (tx_done) begin
                    op_done_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_TX_ERR: begin
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_alu.sv
// Bench for uart_alu: two instances (4-byte and 2-byte operands) driven over their serial lines.
module tb_uart_alu;

    localparam int unsigned CLK_FREQ    = 10000000;
    localparam int unsigned UART_BPS    = 1000000;
    localparam int unsigned TIMEOUT_CYC = 800;
    localparam int          BIT         = CLK_FREQ / UART_BPS;

    logic clk = 1'b0;
    logic rst;
    logic rx_w[2];
    logic tx_w[2];
    logic busy_w[2];
    logic opd_w[2];
    logic fe_w[2];

    int checks = 0;
    int errors = 0;
    int opd_cnt[2] = '{0, 0};
    int fe_cnt[2]  = '{0, 0};
    logic [7:0] rq[2][$];
    logic [7:0] exp_q[$];

    always #50 clk = ~clk;

    uart_alu #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .OP_BYTES(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .RX(rx_w[0]), .TX(tx_w[0]),
        .busy(busy_w[0]), .op_done(opd_w[0]), .frame_err(fe_w[0])
    );

    uart_alu #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .OP_BYTES(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut2 (
        .clk(clk), .rst(rst), .RX(rx_w[1]), .TX(tx_w[1]),
        .busy(busy_w[1]), .op_done(opd_w[1]), .frame_err(fe_w[1])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (opd_w[i] === 1'b1) opd_cnt[i] <= opd_cnt[i] + 1;
            if (fe_w[i] === 1'b1)  fe_cnt[i]  <= fe_cnt[i] + 1;
        end
    end

    // Line receivers: decode each TX byte at mid-bit and queue it.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            logic [7:0] b;
            b = '0;
            wait (rst === 1'b0);
            forever begin
                @(negedge tx_w[g]);
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx_w[g];
                end
                repeat (BIT) @(negedge clk);
                rq[g].push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    function automatic bit is_legal(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h05);
    endfunction

    // Reference: arithmetic on nb-byte unsigned values, response as a byte list.
    task automatic build_expected(input int nb, input logic [7:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, a, b, r;
        logic        c;
        exp_q.delete();
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        c = 1'b0;
        r = '0;
        case (op)
            8'h01: begin r = a + b; c = (a > (mask - b)); end
            8'h02: begin r = a - b; c = (a < b); end
            8'h03: r = a & b;
            8'h04: r = a | b;
            8'h05: r = a ^ b;
            default: begin
                exp_q.push_back(8'hEE);
                return;
            end
        endcase
        r = r & mask;
        for (int i = 0; i < nb; i++) exp_q.push_back(8'(r >> (8 * i)));
        exp_q.push_back({6'b0, (r == 64'd0), c});
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        rx_w[u] = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_w[u] = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_w[u] = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_operands(input int u, input logic [63:0] a, input logic [63:0] b, input int gap_max);
        for (int i = 0; i < nbytes(u); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(u, 8'(a >> (8 * i)));
        end
        for (int i = 0; i < nbytes(u); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_byte(u, 8'(b >> (8 * i)));
        end
    endtask

    task automatic run_frame(input int u, input logic [7:0] op, input logic [63:0] a,
                             input logic [63:0] b, input string tag);
        int od0, fe0;
        od0 = opd_cnt[u];
        fe0 = fe_cnt[u];
        rq[u].delete();
        build_expected(nbytes(u), op, a, b);
        send_byte(u, op);
        check({tag, "/busy_hi"}, 64'(busy_w[u]), 64'd1);
        if (is_legal(op)) send_operands(u, a, b, 150);
        for (int c = 0; c < 20000 && rq[u].size() < exp_q.size(); c++) @(negedge clk);
        repeat (2 * BIT) @(negedge clk);
        check({tag, "/resp_len"}, 64'(rq[u].size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rq[u].size(); i++)
            check($sformatf("%s/byte%0d", tag, i), 64'(rq[u][i]), 64'(exp_q[i]));
        check({tag, "/op_done"}, 64'(opd_cnt[u] - od0), is_legal(op) ? 64'd1 : 64'd0);
        check({tag, "/frame_err"}, 64'(fe_cnt[u] - fe0), 64'd0);
        check({tag, "/busy_lo"}, 64'(busy_w[u]), 64'd0);
    endtask

    initial begin
        int od0, fe0, u;
        logic [7:0] op;
        logic [63:0] a, b;
        rst = 1'b1;
        rx_w[0] = 1'b1;
        rx_w[1] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst/tx", 64'(tx_w[0]), 64'd1);
        check("rst/busy", 64'(busy_w[0]), 64'd0);
        check("rst/op_done", 64'(opd_w[0]), 64'd0);
        check("rst/frame_err", 64'(fe_w[0]), 64'd0);

        run_frame(0, 8'h01, 64'h0000_4040, 64'h0000_8040, "s1_add");
        run_frame(0, 8'h01, 64'hFFFF_FFFF, 64'h0000_0001, "s2_ovf");
        run_frame(0, 8'h02, 64'h0000_0001, 64'h0000_0002, "s3_sub");
        run_frame(0, 8'h05, 64'h1234_5678, 64'h1234_5678, "s3_xor");
        run_frame(0, 8'h7F, 64'd0, 64'd0, "s4_bad");
        run_frame(0, 8'h01, 64'h0000_4040, 64'h0000_8040, "s4_next");

        // Frame abandoned after three operand bytes.
        od0 = opd_cnt[0];
        fe0 = fe_cnt[0];
        rq[0].delete();
        send_byte(0, 8'h01);
        send_byte(0, 8'h40);
        send_byte(0, 8'h40);
        send_byte(0, 8'h00);
        repeat (TIMEOUT_CYC + 200) @(negedge clk);
        check("s5/frame_err", 64'(fe_cnt[0] - fe0), 64'd1);
        check("s5/no_tx", 64'(rq[0].size()), 64'd0);
        check("s5/busy_lo", 64'(busy_w[0]), 64'd0);
        check("s5/op_done", 64'(opd_cnt[0] - od0), 64'd0);
        run_frame(0, 8'h01, 64'h0000_4040, 64'h0000_8040, "s5_after");

        // Reset while the second result byte is on the line.
        od0 = opd_cnt[0];
        rq[0].delete();
        send_byte(0, 8'h01);
        send_operands(0, 64'h0000_4040, 64'h0000_8040, 0);
        for (int c = 0; c < 20000 && rq[0].size() < 1; c++) @(negedge clk);
        check("s6/first_byte", 64'(rq[0].size() >= 1), 64'd1);
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("s6/tx_hi", 64'(tx_w[0]), 64'd1);
        check("s6/busy_lo", 64'(busy_w[0]), 64'd0);
        repeat (15 * BIT) @(negedge clk);
        check("s6/no_op_done", 64'(opd_cnt[0] - od0), 64'd0);
        check("s6/tx_idle", 64'(tx_w[0]), 64'd1);
        rq[0].delete();
        rq[1].delete();
        run_frame(1, 8'h01, 64'h4040, 64'h8040, "s6_ob2");
        run_frame(0, 8'h01, 64'h0000_4040, 64'h0000_8040, "s6_rerun");

        for (int n = 0; n < 14; n++) begin
            u = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                8:       op = 8'h00;
                9:       op = 8'($urandom_range(6, 255));
                default: op = 8'($urandom_range(1, 5));
            endcase
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a;
            run_frame(u, op, a, b, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
